// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared encodings and step classification for the quadrature decoder
package quad_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // A leads B: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic is_up(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev == AB_00) && (cur == AB_10)) ||
               ((prev == AB_10) && (cur == AB_11)) ||
               ((prev == AB_11) && (cur == AB_01)) ||
               ((prev == AB_01) && (cur == AB_00));
    endfunction

    function automatic logic is_dn(input logic [1:0] prev, input logic [1:0] cur);
        return is_up(cur, prev);
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// rtl/quad_debounce.sv - 2-FF synchroniser and sample-tick debouncer for one encoder phase
module quad_debounce #(
    parameter int DEB_COUNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic sample_tick,
    output logic stable
);

    localparam int CNT_W = $clog2(DEB_COUNT + 1);

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = deb_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

    // Any sample agreeing with the held level restarts the run of differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
            stable  <= 1'b0;
        end else if (sample_tick) begin
            if (sync_ff[1] == stable) begin
                deb_cnt <= '0;
            end else if (cnt_inc == CNT_W'(DEB_COUNT)) begin
                stable  <= sync_ff[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder reader driving a wrapping position count
module quad_decoder
    import quad_pkg::*;
#(
    parameter int SAMPLE_DIV = 1600,
    parameter int DEB_COUNT  = 3,
    parameter int CountSize  = 8
) (
    input  logic                 pin3_clk_16mhz,
    input  logic                 pin13,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enable,
    input  logic                 clear,
    output logic [CountSize-1:0] count_out,
    output logic                 dir,
    output logic                 step,
    output logic                 err
);

    localparam int PRESC_W = $clog2(SAMPLE_DIV);

    logic [PRESC_W-1:0] presc;
    logic               sample_tick;
    logic               stable_a;
    logic               stable_b;
    logic [1:0]         ab;
    logic [1:0]         prev_ab;
    logic               up_step;
    logic               dn_step;
    logic               bad_step;

    assign sample_tick = (presc == PRESC_W'(SAMPLE_DIV - 1));

    always_ff @(posedge pin3_clk_16mhz or posedge pin13) begin
        if (pin13) begin
            presc <= '0;
        end else if (sample_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    quad_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_a (
        .clk         (pin3_clk_16mhz),
        .rst         (pin13),
        .raw         (enc_a),
        .sample_tick (sample_tick),
        .stable      (stable_a)
    );

    quad_debounce #(.DEB_COUNT(DEB_COUNT)) u_deb_b (
        .clk         (pin3_clk_16mhz),
        .rst         (pin13),
        .raw         (enc_b),
        .sample_tick (sample_tick),
        .stable      (stable_b)
    );

    assign ab       = {stable_a, stable_b};
    assign up_step  = is_up(prev_ab, ab);
    assign dn_step  = is_dn(prev_ab, ab);
    assign bad_step = (prev_ab ^ ab) == 2'b11;

    always_ff @(posedge pin3_clk_16mhz or posedge pin13) begin
        if (pin13) begin
            prev_ab <= AB_00;
        end else begin
            prev_ab <= ab;
        end
    end

    // clear outranks any step or error seen in the same cycle; dir is left alone.
    always_ff @(posedge pin3_clk_16mhz or posedge pin13) begin
        if (pin13) begin
            count_out <= '0;
            dir       <= DIR_DN;
            step      <= 1'b0;
            err       <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clear) begin
                count_out <= '0;
                err       <= 1'b0;
            end else if (bad_step) begin
                err <= 1'b1;
            end else if (enable && up_step) begin
                count_out <= count_out + 1'b1;
                dir       <= DIR_UP;
                step      <= 1'b1;
            end else if (enable && dn_step) begin
                count_out <= count_out - 1'b1;
                dir       <= DIR_DN;
                step      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;

    localparam int HOLD = 14;

    logic       pin3_clk_16mhz = 1'b0;
    logic       pin13  = 1'b1;
    logic       enc_a  = 1'b0;
    logic       enc_b  = 1'b0;
    logic       enable = 1'b0;
    logic       clear  = 1'b0;
    logic [7:0] count_out;
    logic       dir;
    logic       step;
    logic       err;

    int errors = 0;
    int checks = 0;

    quad_decoder #(
        .SAMPLE_DIV (4),
        .DEB_COUNT  (2),
        .CountSize  (8)
    ) dut (
        .pin3_clk_16mhz (pin3_clk_16mhz),
        .pin13          (pin13),
        .enc_a          (enc_a),
        .enc_b          (enc_b),
        .enable         (enable),
        .clear          (clear),
        .count_out      (count_out),
        .dir            (dir),
        .step           (step),
        .err            (err)
    );

    always #5 pin3_clk_16mhz = ~pin3_clk_16mhz;

    task automatic set_ab(input logic a, input logic b, output int pulses, output int wide);
        logic last;
        pulses = 0;
        wide   = 0;
        last   = 1'b0;
        @(negedge pin3_clk_16mhz);
        enc_a = a;
        enc_b = b;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge pin3_clk_16mhz);
            if (step) begin
                pulses++;
                if (last) wide++;
            end
            last = step;
        end
    endtask

    task automatic pulse_clear();
        @(negedge pin3_clk_16mhz);
        clear = 1'b1;
        @(negedge pin3_clk_16mhz);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        pin13 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge pin3_clk_16mhz);
            enc_a = i[0];
            enc_b = i[1];
            checks++;
            if ({count_out, dir, step, err} !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got count=%0d dir=%b step=%b err=%b, want all 0",
                         i, count_out, dir, step, err);
            end
        end
        enc_a = 1'b0;
        enc_b = 1'b0;
        @(negedge pin3_clk_16mhz);
        pin13 = 1'b0;
        repeat (HOLD) @(negedge pin3_clk_16mhz);
        checks++;
        if ({count_out, dir, step, err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: got count=%0d dir=%b step=%b err=%b, want all 0",
                     count_out, dir, step, err);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        int p, w, total, wides;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        enable = 1'b1;
        total = 0;
        wides = 0;
        for (int i = 0; i < 4; i++) begin
            set_ab(seq[i][1], seq[i][0], p, w);
            total += p;
            wides += w;
            checks++;
            if (count_out !== 8'(i + 1)) begin
                errors++;
                $display("FAIL fwd_count step %0d: got %0d want %0d", i, count_out, i + 1);
            end
        end
        checks++;
        if (total !== 4 || wides !== 0) begin
            errors++;
            $display("FAIL fwd_pulses: got %0d pulses (%0d widened), want 4 single-cycle", total, wides);
        end
        checks++;
        if (dir !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_flags: got dir=%b err=%b, want dir=1 err=0", dir, err);
        end
    endtask

    task automatic test_wrap();
        int p, w;
        pulse_clear();
        checks++;
        if (count_out !== 8'd0) begin
            errors++;
            $display("FAIL wrap_clear: got %0d want 0", count_out);
        end
        set_ab(1'b0, 1'b1, p, w);
        checks++;
        if (count_out !== 8'd255 || dir !== 1'b0 || p !== 1) begin
            errors++;
            $display("FAIL wrap_down: got count=%0d dir=%b pulses=%0d, want 255 0 1", count_out, dir, p);
        end
        set_ab(1'b0, 1'b0, p, w);
        checks++;
        if (count_out !== 8'd0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up0: got count=%0d dir=%b, want 0 1", count_out, dir);
        end
        set_ab(1'b1, 1'b0, p, w);
        checks++;
        if (count_out !== 8'd1) begin
            errors++;
            $display("FAIL wrap_up1: got %0d want 1", count_out);
        end
        set_ab(1'b0, 1'b0, p, w);
        checks++;
        if (count_out !== 8'd0 || dir !== 1'b0) begin
            errors++;
            $display("FAIL wrap_back: got count=%0d dir=%b, want 0 0", count_out, dir);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        @(negedge pin3_clk_16mhz);
        enc_a = 1'b1;
        repeat (3) @(negedge pin3_clk_16mhz);
        enc_a = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge pin3_clk_16mhz);
            if (step) pulses++;
        end
        checks++;
        if (pulses !== 0 || count_out !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL glitch: got pulses=%0d count=%0d err=%b, want 0 0 0", pulses, count_out, err);
        end
    endtask

    task automatic test_illegal_clear();
        int p, w;
        set_ab(1'b1, 1'b0, p, w);
        set_ab(1'b1, 1'b1, p, w);
        set_ab(1'b0, 1'b0, p, w);
        checks++;
        if (err !== 1'b1 || count_out !== 8'd2 || p !== 0) begin
            errors++;
            $display("FAIL illegal: got err=%b count=%0d pulses=%0d, want 1 2 0", err, count_out, p);
        end
        pulse_clear();
        checks++;
        if (err !== 1'b0 || count_out !== 8'd0) begin
            errors++;
            $display("FAIL clear: got err=%b count=%0d, want 0 0", err, count_out);
        end
        @(negedge pin3_clk_16mhz);
        clear = 1'b1;
        set_ab(1'b0, 1'b1, p, w);
        checks++;
        if (p !== 0 || count_out !== 8'd0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_step: got pulses=%0d count=%0d dir=%b, want 0 0 1", p, count_out, dir);
        end
        clear = 1'b0;
    endtask

    task automatic test_enable_async_reset();
        logic [1:0] seq [3];
        logic [1:0] fwd [5];
        int p, w, total;
        seq = '{2'b00, 2'b10, 2'b11};
        fwd = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        enable = 1'b0;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            set_ab(seq[i][1], seq[i][0], p, w);
            total += p;
        end
        checks++;
        if (total !== 0 || count_out !== 8'd0) begin
            errors++;
            $display("FAIL enable_off: got pulses=%0d count=%0d, want 0 0", total, count_out);
        end
        enable = 1'b1;
        set_ab(fwd[0][1], fwd[0][0], p, w);
        checks++;
        if (count_out !== 8'd1 || p !== 1) begin
            errors++;
            $display("FAIL enable_on: got count=%0d pulses=%0d, want 1 1", count_out, p);
        end
        for (int i = 1; i < 5; i++) set_ab(fwd[i][1], fwd[i][0], p, w);
        checks++;
        if (count_out !== 8'd5) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d want 5", count_out);
        end
        @(negedge pin3_clk_16mhz);
        #2 pin13 = 1'b1;
        #1;
        checks++;
        if ({count_out, dir, step, err} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d dir=%b step=%b err=%b, want all 0",
                     count_out, dir, step, err);
        end
        @(negedge pin3_clk_16mhz);
        pin13 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_glitch();
        test_illegal_clear();
        test_enable_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Quadrature encoder reader; the input-side counterpart of the board's free-running LED up counter. Two raw encoder phases A/B enter from board pins. They are synchronised, debounced and decoded into up/down steps, which drive a wrapping N-bit position count shown on the LED pins. Lives beside the top level on the TinyFPGA-B2 and runs entirely in the 16 MHz domain.

Parameters:
- SAMPLE_DIV, 1600: clock cycles per debounce sample tick (10 kHz at 16 MHz); must be ≥ 2.
- DEB_COUNT, 3: consecutive differing samples needed to accept a new level on a channel; must be ≥ 1.
- CountSize, 8: position counter width.

Ports:
- pin3_clk_16mhz  in  1  16 MHz board clock; the only clock.
- pin13  in  1  Reset, asynchronous, active-high.
- enc_a  in  1  Raw encoder phase A, asynchronous to the clock.
- enc_b  in  1  Raw encoder phase B, asynchronous to the clock.
- enable  in  1  Count enable, active-high, synchronous.
- clear  in  1  Synchronous clear of the count and error flag, active-high.
- count_out  out  CountSize  Position count.
- dir  out  1  Direction of the last accepted step: 1 = up, 0 = down.
- step  out  1  One-cycle pulse per accepted, enabled step.
- err  out  1  Sticky illegal-transition flag.

Behaviour:
- Reset (pin13=1, async): count_out=0, dir=0, step=0, err=0. Synchronisers, debounced levels and previous-AB register all return to 0. Prescaler and debounce counters return to 0.
- Reset mid-operation: outputs clear immediately, without waiting for a clock edge. Operation resumes on the first edge after deassertion.
- Synchroniser: 2-FF chain per channel, feeding the debouncer.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps to 0. sample_tick is high for one cycle when the count equals SAMPLE_DIV-1.
- Debounce, per channel, evaluated only on sample_tick:
  - synced == stable: deb_cnt <= 0.
  - Otherwise deb_cnt increments. When the incremented value reaches DEB_COUNT, stable <= synced and deb_cnt <= 0.
- Decoder: AB = {stable_a, stable_b}, compared each cycle against prev_AB; prev_AB <= AB every cycle.
  - Up sequence: 00→10→11→01→00 (A leads).
  - Down sequence: the reverse of the up sequence.
  - No change: nothing happens.
  - Legal up/down step with enable=1: count_out ±1, dir set accordingly, step=1 for exactly that cycle.
  - Legal step with enable=0: count_out, dir and step unchanged; prev_AB still tracks.
  - Both bits changed (00↔11, 10↔01): err <= 1; count_out, dir and step unchanged.
- Arithmetic: modulo 2^CountSize. All-ones +1 → 0; 0 −1 → all-ones. No saturation.
- clear=1: count_out <= 0 and err <= 0. clear wins over a step in the same cycle, so step stays 0 in that cycle. dir is unaffected.
- Latency, encoder pin edge to count_out update:
  - 2 cycles of synchroniser, plus
  - debounce of between (DEB_COUNT−1)·SAMPLE_DIV+1 and DEB_COUNT·SAMPLE_DIV cycles, plus
  - 1 decode cycle.
- Glitches shorter than DEB_COUNT consecutive samples are never seen by the decoder.
- All outputs are registered.

Decomposition:
- Shared package quad_pkg holds:
  - AB encodings: AB_00=2'b00, AB_10=2'b10, AB_11=2'b11, AB_01=2'b01.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Function is_up(prev,cur) and function is_dn(prev,cur).
- One sub-module, quad_debounce: synchroniser plus debounce counter for a single channel, parameterised by DEB_COUNT. Instantiated twice, sharing the sample_tick from the parent's prescaler.

Test Plan:
Bench overrides SAMPLE_DIV=4 and DEB_COUNT=2. Each encoder level is held ≥ 12 cycles.
- Reset: pin13=1 with encoder inputs toggling → count_out=0, dir=0, step=0, err=0 throughout.
- Forward: enable=1, drive AB 00→10→11→01→00 → count_out=4, dir=1, exactly 4 single-cycle step pulses, err=0.
- Wrap: from count_out=0, one down step (00→01) → count_out=255, dir=0. Then 00→10 twice-forward from 255 → count_out wraps 255→0→1.
- Glitch rejection: A pulsed high for 3 cycles (less than one sample period) → no step pulse, count_out unchanged.
- Illegal and clear:
  - Jump AB 00→11 → err=1, count_out unchanged.
  - Then clear=1 for 1 cycle → count_out=0, err=0.
  - clear coincident with a legal step → count_out=0 and step=0.
- Enable and async reset:
  - enable=0 during 3 forward steps → count_out unchanged, no step pulses. Re-enable plus 1 step → count_out +1.
  - Assert pin13 between clock edges while count_out=5 → count_out=0 before the next edge.
